fft_mag_packer: RTL and testbench
=================================

// Module: fft_mag_packer
// PURPOSE
//  Downstream of the FFT control stage: takes the FFT result stream (re/im, valid, bin index), computes a
//  per-bin magnitude estimate, scales and saturates it, and writes 16-bit words into the UART-side FIFO.
//  Only the first OUT_BINS bins are forwarded, which is the unique half of a real-input spectrum.
//  The FFT output is never stalled (its tready is tied high), so overflow is handled by dropping frames.
// PARAMETERS
//  DATA_W    32   width of fft_re / fft_im, two's complement
//  IDX_W     16   width of fft_index
//  MAG_W     16   output magnitude width; fifo_wdata width
//  SHIFT     8    right shift applied to the raw magnitude before saturation
//  OUT_BINS  512  bins forwarded per frame (indices 0..OUT_BINS-1); must be less than the FFT length
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  fft_re      in   DATA_W  real part of the FFT output
//  fft_im      in   DATA_W  imaginary part of the FFT output
//  fft_valid   in   1       fft_re, fft_im and fft_index are valid this cycle
//  fft_index   in   IDX_W   bin index (FFT tuser)
//  fifo_full   in   1       downstream FIFO full; no write is issued while high
//  fifo_wdata  out  MAG_W   word to the FIFO
//  fifo_wr_en  out  1       FIFO write strobe
//  frame_done  out  1       one-cycle pulse when bin OUT_BINS-1 of a passing frame enters the queue
//  ovf_flag    out  1       sticky overflow flag
//  ovf_clr     in   1       clears ovf_flag
//  drop_cnt    out  8       count of dropped or truncated frames; saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0, queue empty, pipeline flushed, state = WAIT_SOF.
//  - Datapath: 3-stage pipeline, always running.
//    - S1: a = |re|, b = |im|, unsigned DATA_W bits, so -2^(DATA_W-1) maps to 2^(DATA_W-1).
//    - S2: mx = max(a,b), mn = min(a,b).
//    - S3: m = mx + (mn>>2) + (mn>>3), computed in DATA_W+1 bits; then m >>= SHIFT;
//      the result saturates to 2^MAG_W-1.
//  - The index and a "keep" bit travel alongside the data; keep = fft_valid && state allows && index < OUT_BINS.
//  - Output queue: 2 entries. Push at S3 when keep is set. Pop when queue is non-empty and !fifo_full;
//    the pop drives fifo_wr_en=1 and fifo_wdata=head in the same registered cycle.
//  - Latency: fft_valid to fifo_wr_en is 3 cycles when the queue is empty and fifo_full=0.
//  - A push and a pop in the same cycle are both honoured.
//  - FSM is evaluated on S3 words:
//    - WAIT_SOF: discard everything. Go to PASS on a word with index==0.
//    - PASS: push words. On index==OUT_BINS-1, pulse frame_done and go to WAIT_SOF.
//      On a push while the queue is full (and no pop that cycle): discard the word, set ovf_flag,
//      increment drop_cnt, go to DROP.
//    - DROP: discard words. Go to PASS on index==0; that word is pushed.
//    - index==0 arriving in PASS before OUT_BINS-1: truncated frame. drop_cnt increments, the FSM stays in PASS
//      and the new frame starts with that word.
//  - Words already queued when a drop occurs are still written to the FIFO.
//  - ovf_clr and a new overflow in the same cycle: the set wins.
//  - Reset mid-frame: the queue contents are lost, and nothing is written until the next index 0.
// CONFIGURATION
//  - MAG_FRAME_HDR_EN defined:
//    - When bin 0 is pushed, word 16'hA55A is pushed first, in the same cycle, as the queue's oldest entry.
//    - Queue depth becomes 3 so that both words fit.
//    - The extra word drains during the gap while bins OUT_BINS..N-1 are discarded.
//    - Each forwarded frame produces OUT_BINS+1 writes.
//  - MAG_FRAME_HDR_EN undefined: no header word, queue depth 2, OUT_BINS writes per frame.
// TESTING
//  - re=32'h00001000, im=32'hFFFFF000, index 0, fifo_full=0 -> 3 cycles later fifo_wr_en=1, fifo_wdata=16'h0016
//    (4096+1536=5632, >>8 = 22).
//  - re=32'h7FFFFFFF, im=32'h80000000, index 0 -> fifo_wdata=16'hFFFF (saturated).
//  - One continuous 1024-bin frame, index 0..1023, fifo_full=0 -> exactly 512 writes (513 with header),
//    one frame_done pulse, drop_cnt=0.
//  - fifo_full held high for 4 cycles from bin 100 -> ovf_flag=1, drop_cnt=1; the queued words drain after
//    fifo_full falls, then no writes until the next index 0, after which 512 writes follow.
//  - rst_n pulsed low during bin 200, then index 201..1023 followed by a new frame
//    -> no writes until the new index 0, then 512 writes.
//  - ovf_clr=1 in the same cycle as a new overflow -> ovf_flag stays 1; ovf_clr alone -> ovf_flag=0 on the next cycle.

Source files
------------

// File: rtl/fft_mag_packer.sv
// FFT magnitude packer: |re|,|im| -> alpha-max-beta-min estimate, scaled, saturated, framed into a FIFO.
// Latency: 3 cycles from fft_valid to fifo_wr_en when the queue is empty and fifo_full is low.
// Backpressure: FFT input is never stalled; a full queue under fifo_full drops the rest of the frame.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   fft_re, fft_im, fft_valid  FFT result stream (two's complement), valid this cycle
//   fft_index                  bin index of the current FFT word
//   fifo_full                  downstream FIFO full; no write is issued while high
//   fifo_wdata, fifo_wr_en     registered write port to the downstream FIFO
//   frame_done                 one-cycle pulse when the last forwarded bin of a frame is accepted
//   ovf_flag, ovf_clr          sticky overflow flag and its clear (a new overflow wins over the clear)
//   drop_cnt                   saturating count of dropped or truncated frames
//
// Build option: define MAG_FRAME_HDR_EN to prefix every frame with header word 16'hA55A
// (queue depth grows from 2 to 3 so header and bin 0 can be accepted in one cycle).

module fft_mag_packer #(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 16,
  parameter int MAG_W    = 16,
  parameter int SHIFT    = 8,
  parameter int OUT_BINS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fft_re,
  input  logic [DATA_W-1:0] fft_im,
  input  logic              fft_valid,
  input  logic [IDX_W-1:0]  fft_index,
  input  logic              fifo_full,
  output logic [MAG_W-1:0]  fifo_wdata,
  output logic              fifo_wr_en,
  output logic              frame_done,
  output logic              ovf_flag,
  input  logic              ovf_clr,
  output logic [7:0]        drop_cnt
);

`ifdef MAG_FRAME_HDR_EN
  localparam bit HDR_EN = 1'b1;
  localparam int DEPTH  = 3;
`else
  localparam bit HDR_EN = 1'b0;
  localparam int DEPTH  = 2;
`endif

  // Occupancy plus up to two pushes fits in 3 bits; the staging array is sized
  // to the full index range so any 3-bit index is in bounds.
  localparam int CNT_W = 3;
  localparam int ENT_N = 1 << CNT_W;

  localparam logic [MAG_W-1:0]  HDR_WORD = MAG_W'(16'hA55A);
  localparam logic [DATA_W:0]   MAG_MAX  = (DATA_W+1)'({MAG_W{1'b1}});
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OUT_BINS - 1);
  localparam logic [IDX_W-1:0]  BINS_IDX = IDX_W'(OUT_BINS);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PASS     = 2'd1,
    DROP     = 2'd2
  } state_t;

  // |x| as an unsigned value: the most negative input maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_u(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? ((~x) + DATA_W'(1)) : x;
  endfunction

  state_t             state;

  // Stage 1: absolute values.
  logic               s1_vld;
  logic [IDX_W-1:0]   s1_idx;
  logic [DATA_W-1:0]  s1_a;
  logic [DATA_W-1:0]  s1_b;

  // Stage 2: max/min.
  logic               s2_vld;
  logic [IDX_W-1:0]   s2_idx;
  logic [DATA_W-1:0]  s2_mx;
  logic [DATA_W-1:0]  s2_mn;

  // Output queue, q[0] is the oldest entry.
  logic [MAG_W-1:0]   q [DEPTH];
  logic [CNT_W-1:0]   cnt;

  // Stage 3 (combinational into the output registers).
  logic [DATA_W:0]    mx_e;
  logic [DATA_W:0]    mn_e;
  logic [DATA_W:0]    m_sum;
  logic [DATA_W:0]    m_sh;
  logic [MAG_W-1:0]   mag;

  logic               is_first;
  logic               is_last;
  logic               in_range;
  logic               want;
  logic               trunc;
  logic               hdr_push;
  logic               pop_req;
  logic               fits;
  logic               overflow;
  logic               accept;
  logic               pop;
  logic [1:0]         n_req;
  logic [1:0]         n_push;
  logic [CNT_W-1:0]   total_req;
  logic [CNT_W-1:0]   total_eff;
  logic [CNT_W-1:0]   cnt_p1;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [MAG_W-1:0]   w0;
  logic [MAG_W-1:0]   ent   [ENT_N];
  logic [MAG_W-1:0]   q_nxt [DEPTH];

  always_comb begin
    mx_e  = {1'b0, s2_mx};
    mn_e  = {1'b0, s2_mn};
    m_sum = mx_e + (mn_e >> 2) + (mn_e >> 3);
    m_sh  = m_sum >> SHIFT;
    mag   = (m_sh > MAG_MAX) ? {MAG_W{1'b1}} : m_sh[MAG_W-1:0];

    is_first = (s2_idx == '0);
    is_last  = (s2_idx == LAST_IDX);
    in_range = (s2_idx < BINS_IDX);

    // A word is wanted while a frame is passing, or when it starts a new frame.
    want  = s2_vld && in_range && ((state == PASS) || is_first);
    // Bin 0 seen while still passing means the previous frame never completed.
    trunc = s2_vld && (state == PASS) && is_first;

    hdr_push  = HDR_EN && is_first;
    n_req     = want ? (hdr_push ? 2'd2 : 2'd1) : 2'd0;
    total_req = cnt + CNT_W'(n_req);
    pop_req   = !fifo_full && (total_req != '0);
    fits      = (total_req - CNT_W'(pop_req)) <= CNT_W'(DEPTH);
    overflow  = want && !fits;
    accept    = want && fits;

    n_push    = accept ? n_req : 2'd0;
    total_eff = cnt + CNT_W'(n_push);
    pop       = !fifo_full && (total_eff != '0);
    cnt_nxt   = total_eff - CNT_W'(pop);
    cnt_p1    = cnt + CNT_W'(1);

    // Lay out queue contents followed by incoming words; slots past total_eff
    // are don't-care, so the pushes can be written unconditionally.
    w0 = hdr_push ? HDR_WORD : mag;
    for (int i = 0; i < ENT_N; i++) begin
      ent[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent[i] = q[i];
    end
    ent[cnt]    = w0;
    ent[cnt_p1] = mag;

    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = pop ? ent[i+1] : ent[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SOF;
      s1_vld     <= 1'b0;
      s1_idx     <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_vld     <= 1'b0;
      s2_idx     <= '0;
      s2_mx      <= '0;
      s2_mn      <= '0;
      cnt        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      fifo_wdata <= '0;
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      ovf_flag   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      s1_vld <= fft_valid;
      s1_idx <= fft_index;
      s1_a   <= abs_u(fft_re);
      s1_b   <= abs_u(fft_im);

      s2_vld <= s1_vld;
      s2_idx <= s1_idx;
      s2_mx  <= (s1_a >= s1_b) ? s1_a : s1_b;
      s2_mn  <= (s1_a >= s1_b) ? s1_b : s1_a;

      if (overflow) begin
        state <= DROP;
      end else if (accept) begin
        state <= is_last ? WAIT_SOF : PASS;
      end

      cnt <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end

      fifo_wr_en <= pop;
      if (pop) begin
        fifo_wdata <= ent[0];
      end

      frame_done <= accept && is_last;

      if (overflow) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end

      if ((overflow || trunc) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_mag_packer.sv
// Directed bench for fft_mag_packer: reset state, latency, magnitude values,
// full frames, overflow/drop, ovf_clr priority, truncated frames, mid-frame reset.
// Handles both builds (with and without MAG_FRAME_HDR_EN).

module tb_fft_mag_packer;

  localparam int DATA_W   = 32;
  localparam int IDX_W    = 16;
  localparam int MAG_W    = 16;
  localparam int OUT_BINS = 512;

`ifdef MAG_FRAME_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] fft_re = '0;
  logic [DATA_W-1:0] fft_im = '0;
  logic              fft_valid = 1'b0;
  logic [IDX_W-1:0]  fft_index = '0;
  logic              fifo_full = 1'b0;
  logic [MAG_W-1:0]  fifo_wdata;
  logic              fifo_wr_en;
  logic              frame_done;
  logic              ovf_flag;
  logic              ovf_clr = 1'b0;
  logic [7:0]        drop_cnt;

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;
  logic [MAG_W-1:0] wr_q[$];

  fft_mag_packer #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .MAG_W    (MAG_W),
    .SHIFT    (8),
    .OUT_BINS (OUT_BINS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fft_re     (fft_re),
    .fft_im     (fft_im),
    .fft_valid  (fft_valid),
    .fft_index  (fft_index),
    .fifo_full  (fifo_full),
    .fifo_wdata (fifo_wdata),
    .fifo_wr_en (fifo_wr_en),
    .frame_done (frame_done),
    .ovf_flag   (ovf_flag),
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Capture every FIFO write and frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_wr_en) wr_q.push_back(fifo_wdata);
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (i >= 0 && i < wr_q.size()) return 32'(wr_q[i]);
    return 32'hDEAD_BEEF;
  endfunction

  // Advance n cycles, then settle past the following negedge so the monitor has run.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    fft_valid = 1'b0; fifo_full = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Bin i carries re = i<<8, im = 0, so its magnitude word equals i.
  task automatic send_frame(input int first, input int last, input int full_at, input int clr_at);
    for (int i = first; i <= last; i++) begin
      @(posedge clk); #1;
      fft_valid = 1'b1;
      fft_index = IDX_W'(i);
      fft_re    = DATA_W'(i << 8);
      fft_im    = '0;
      fifo_full = (full_at >= 0) && (i >= full_at) && (i < full_at + 4);
      ovf_clr   = (i == clr_at);
    end
    @(posedge clk); #1;
    fft_valid = 1'b0; fifo_full = 1'b0; ovf_clr = 1'b0;
  endtask

  int base;
  int fd0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_wdata", 32'(fifo_wdata), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(ovf_flag), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Latency and basic magnitude: 4096 + 1536 = 5632, >>8 = 22
    @(posedge clk); #1;
    fft_valid = 1'b1; fft_index = '0; fft_re = 32'h0000_1000; fft_im = 32'hFFFF_F000;
    @(posedge clk); #1;
    fft_valid = 1'b0;
    @(negedge clk); check("lat1_wr_en", 32'(fifo_wr_en), 32'd0);
    @(negedge clk); check("lat2_wr_en", 32'(fifo_wr_en), 32'd0);
    @(negedge clk); check("lat3_wr_en", 32'(fifo_wr_en), 32'd1);
`ifdef MAG_FRAME_HDR_EN
    check("lat3_hdr", 32'(fifo_wdata), 32'h0000_A55A);
    @(negedge clk); check("lat4_wr_en", 32'(fifo_wr_en), 32'd1);
`endif
    check("lat_mag", 32'(fifo_wdata), 32'h0000_0016);

    // Saturation, then a vector where im dominates: 65536 + 192 + 96 = 65824, >>8 = 257
    do_reset();
    base = wr_q.size();
    @(posedge clk); #1;
    fft_valid = 1'b1; fft_index = 16'd0; fft_re = 32'h7FFF_FFFF; fft_im = 32'h8000_0000;
    @(posedge clk); #1;
    fft_index = 16'd1; fft_re = 32'h0000_0300; fft_im = 32'hFFFF_0000;
    @(posedge clk); #1;
    fft_valid = 1'b0;
    idle(8);
    check("sat_writes", 32'(wr_q.size() - base), 32'(2 + HDR));
    check("sat_word", word_at(base + HDR), 32'h0000_FFFF);
    check("minmax_word", word_at(base + HDR + 1), 32'h0000_0101);

    // One clean 1024-bin frame
    do_reset();
    base = wr_q.size(); fd0 = fd_cnt;
    send_frame(0, 1023, -1, -1);
    idle(12);
    check("frm_writes", 32'(wr_q.size() - base), 32'(OUT_BINS + HDR));
    check("frm_done", 32'(fd_cnt - fd0), 32'd1);
    check("frm_drop", 32'(drop_cnt), 32'd0);
    check("frm_first", word_at(base), (HDR == 1) ? 32'h0000_A55A : 32'd0);
    check("frm_bin1", word_at(base + HDR + 1), 32'd1);
    check("frm_last", word_at(wr_q.size() - 1), 32'(OUT_BINS - 1));
    check("frm_ovf", 32'(ovf_flag), 32'd0);

    // fifo_full for 4 cycles from bin 100: bins 0..99 written, bin 100 overflows
    base = wr_q.size(); fd0 = fd_cnt;
    send_frame(0, 1023, 100, -1);
    idle(12);
    check("ovf_flag", 32'(ovf_flag), 32'd1);
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    check("ovf_writes", 32'(wr_q.size() - base), 32'(100 + HDR));
    check("ovf_last", word_at(wr_q.size() - 1), 32'd99);
    check("ovf_done", 32'(fd_cnt - fd0), 32'd0);
    base = wr_q.size(); fd0 = fd_cnt;
    send_frame(0, 1023, -1, -1);
    idle(12);
    check("rec_writes", 32'(wr_q.size() - base), 32'(OUT_BINS + HDR));
    check("rec_done", 32'(fd_cnt - fd0), 32'd1);
    check("rec_drop", 32'(drop_cnt), 32'd1);

    // ovf_clr alone clears the flag on the next cycle
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_alone", 32'(ovf_flag), 32'd0);

    // ovf_clr coincident with the overflow at bin 100 (decided while bin 102 is driven)
    send_frame(0, 1023, 100, 102);
    idle(12);
    check("clr_vs_set", 32'(ovf_flag), 32'd1);
    check("clr_vs_drop", 32'(drop_cnt), 32'd2);

    // Truncated frame: bin 0 again after bin 300
    base = wr_q.size(); fd0 = fd_cnt;
    send_frame(0, 300, -1, -1);
    send_frame(0, 1023, -1, -1);
    idle(12);
    check("trunc_drop", 32'(drop_cnt), 32'd3);
    check("trunc_writes", 32'(wr_q.size() - base), 32'(301 + OUT_BINS + 2 * HDR));
    check("trunc_done", 32'(fd_cnt - fd0), 32'd1);

    // Reset during bin 200: nothing written until the next bin 0
    send_frame(0, 199, -1, -1);
    @(posedge clk); #1;
    rst_n = 1'b0; fft_valid = 1'b1; fft_index = 16'd200; fft_re = DATA_W'(200 << 8);
    @(posedge clk); #1;
    rst_n = 1'b1; fft_valid = 1'b0;
    @(negedge clk); #1;
    base = wr_q.size(); fd0 = fd_cnt;
    check("mrst_drop", 32'(drop_cnt), 32'd0);
    check("mrst_ovf", 32'(ovf_flag), 32'd0);
    send_frame(201, 1023, -1, -1);
    idle(12);
    check("mrst_silent", 32'(wr_q.size() - base), 32'd0);
    send_frame(0, 1023, -1, -1);
    idle(12);
    check("mrst_writes", 32'(wr_q.size() - base), 32'(OUT_BINS + HDR));
    check("mrst_done", 32'(fd_cnt - fd0), 32'd1);
    check("mrst_bin0", word_at(base + HDR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
